// File: rtl/half_max_abs_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : half_max_pkg
// Purpose  : half-precision type and magnitude helper shared by the sequencer
// Revision : 1.0
// ============================================================================
package half_max_pkg;

    typedef logic [15:0] half_t;

    localparam logic [14:0] HALF_MAG_MASK = 15'h7FFF;

    // Raw magnitude bits; NaN payloads compare above +inf on purpose.
    function automatic logic [14:0] half_mag(input half_t h);
        return h[14:0] & HALF_MAG_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/half_max_abs_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : half_max_abs_seq_if
// Purpose   : chunk stream in plus issue/result link to the max-abs engine
// Revision  : 1.0
// ============================================================================
interface half_max_abs_seq_if #(
    parameter int LANES = 8
);
    import half_max_pkg::*;

    logic                      s_valid;
    logic                      s_ready;
    half_t [LANES-1:0]         s_data;
    logic                      eng_in_valid;
    half_t [LANES-1:0]         eng_vector;
    logic                      eng_out_valid;
    logic [$clog2(LANES)-1:0]  eng_index;
    half_t                     eng_c;

    modport master (
        output s_valid, s_data, eng_out_valid, eng_index, eng_c,
        input  s_ready, eng_in_valid, eng_vector
    );

    modport slave (
        input  s_valid, s_data, eng_out_valid, eng_index, eng_c,
        output s_ready, eng_in_valid, eng_vector
    );

endinterface
`default_nettype wire

// File: rtl/half_max_abs_seq_acc.sv
`default_nettype none
// ============================================================================
// Module   : half_max_abs_acc
// Purpose  : running max magnitude and its global index, strict-greater update
// Revision : 1.0
// ============================================================================
module half_max_abs_acc #(
    parameter int IDX_W = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             upd_i,
    input  wire logic [14:0]      cand_mag_i,
    input  wire logic [IDX_W-1:0] cand_idx_i,
    output logic [14:0]           max_o,
    output logic [IDX_W-1:0]      idx_o
);
    logic [14:0]      max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Strict compare: an equal later candidate never displaces an earlier index.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (clr_i) begin
            max_d = '0;
            idx_d = '0;
        end else if (upd_i && (cand_mag_i > max_q)) begin
            max_d = cand_mag_i;
            idx_d = cand_idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    assign max_o = max_q;
    assign idx_o = idx_q;

endmodule
`default_nettype wire

// File: rtl/half_max_abs_seq.sv
`default_nettype none
// ============================================================================
// Module   : half_max_abs_seq
// Purpose  : streams a half vector through a LANES-wide max-abs engine, folds
//            per-chunk winners into one global max/index per job
// Revision : 1.0
// ============================================================================
module half_max_abs_seq
    import half_max_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int MAX_LEN = 1024,
    parameter int LAT_MAX = 8
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         start_i,
    input  wire logic [$clog2(MAX_LEN+1)-1:0] len_i,
    output logic                              busy_o,
    output logic                              result_valid_o,
    output logic [$clog2(MAX_LEN)-1:0]        result_index_o,
    output half_t                             result_max_o,
    half_max_abs_seq_if.slave                 bus
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int LANE_W = $clog2(LANES);
    localparam int NCH_W  = $clog2(MAX_LEN / LANES + 1);
    localparam int WAIT_W = $clog2(LAT_MAX + 1) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [NCH_W-1:0]  nchunks_q,  nchunks_d;
    logic [NCH_W-1:0]  issued_q,   issued_d;
    logic [NCH_W-1:0]  received_q, received_d;
    logic [LANE_W-1:0] tail_q,     tail_d;
    logic [IDX_W-1:0]  res_idx_q,  res_idx_d;
    half_t             res_max_q,  res_max_d;
    logic [WAIT_W-1:0] wait_q,     wait_d;

    logic [LEN_W-1:0]  w_len;
    logic [LEN_W:0]    w_len_rnd;
    logic [NCH_W-1:0]  w_nch;
    logic              w_accept, w_last, w_active, w_eng_acc, w_pending;
    logic [14:0]       w_acc_max;
    logic [IDX_W-1:0]  w_acc_idx, w_cand_idx;

    assign w_len     = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
    assign w_len_rnd = {1'b0, w_len} + (LEN_W+1)'(LANES - 1);
    assign w_nch     = NCH_W'(w_len_rnd >> LANE_W);

    assign w_active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.s_ready      = (state_q == ST_RUN) && (issued_q < nchunks_q);
    assign w_accept         = bus.s_valid && bus.s_ready;
    assign bus.eng_in_valid = w_accept;
    assign w_last           = (issued_q == nchunks_q - NCH_W'(1));
    assign w_eng_acc        = bus.eng_out_valid && w_active;
    assign w_cand_idx       = IDX_W'({received_q, bus.eng_index});
    assign w_pending        = w_active && (issued_q != received_q);

    // Lanes past the job length on the final chunk must never win.
    always_comb begin
        bus.eng_vector = bus.s_data;
        for (int i = 0; i < LANES; i++) begin
            if (w_last && (tail_q != '0) && (LANE_W'(i) >= tail_q)) begin
                bus.eng_vector[i] = '0;
            end
        end
    end

    half_max_abs_acc #(
        .IDX_W (IDX_W)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      ((state_q == ST_IDLE) && start_i),
        .upd_i      (w_eng_acc),
        .cand_mag_i (half_mag(bus.eng_c)),
        .cand_idx_i (w_cand_idx),
        .max_o      (w_acc_max),
        .idx_o      (w_acc_idx)
    );

    always_comb begin
        state_d    = state_q;
        nchunks_d  = nchunks_q;
        tail_d     = tail_q;
        issued_d   = issued_q;
        received_d = received_q;
        res_idx_d  = res_idx_q;
        res_max_d  = res_max_q;
        if (w_accept)  issued_d   = issued_q + NCH_W'(1);
        if (w_eng_acc) received_d = received_q + NCH_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    nchunks_d  = w_nch;
                    tail_d     = w_len[LANE_W-1:0];
                    issued_d   = '0;
                    received_d = '0;
                    if (w_len == '0) begin
                        state_d   = ST_DONE;
                        res_idx_d = '0;
                        res_max_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN:   if (w_accept && w_last) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (received_q == nchunks_q) begin
                    state_d   = ST_DONE;
                    res_idx_d = w_acc_idx;
                    res_max_d = {1'b0, w_acc_max};
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Cycles an issued chunk has waited with no engine result; watchdog only.
    always_comb begin
        wait_d = '0;
        if (w_pending && !w_eng_acc) wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            nchunks_q  <= '0;
            tail_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            res_idx_q  <= '0;
            res_max_q  <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            nchunks_q  <= nchunks_d;
            tail_q     <= tail_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            res_idx_q  <= res_idx_d;
            res_max_q  <= res_max_d;
            wait_q     <= wait_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (received_q <= issued_q);
            assert (wait_q < WAIT_W'(LAT_MAX));
        end
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign result_valid_o = (state_q == ST_DONE);
    assign result_index_o = res_idx_q;
    assign result_max_o   = res_max_q;

endmodule
`default_nettype wire

// File: doc/half_max_abs_seq.md
Name: half_max_abs_seq

Overview:
- Sequencer that computes the max-|x| element of a long half-precision vector of programmable length, up to MAX_LEN elements.
- Accepts the vector as a valid/ready stream of LANES-wide chunks and issues one chunk per beat to an external pipelined LANES-wide max-abs engine.
- Folds the per-chunk engine results into a running max and global element index, then reports the result once per job.
- Sits between a vector-source DMA/buffer and the shared max-abs engine.

Parameters:
- LANES, 8, elements per chunk and engine width; power of 2, >= 2.
- MAX_LEN, 1024, maximum job length in elements; multiple of LANES.
- LAT_MAX, 8, maximum engine latency in cycles; assertion bound only, not used by the RTL.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  $clog2(MAX_LEN+1)  job length in elements; sampled with start.
- busy  out  1  high in RUN, DRAIN and DONE.
- s_valid  in  1  chunk valid.
- s_ready  out  1  chunk accept.
- s_data  in  16 x LANES  chunk; lane i holds element chunk*LANES+i.
- eng_in_valid  out  1  chunk issue to engine.
- eng_vector  out  16 x LANES  chunk to engine, with tail lanes zeroed.
- eng_out_valid  in  1  engine result strobe; results return in issue order.
- eng_index  in  $clog2(LANES)  winning lane.
- eng_c  in  16  winning magnitude; bit15 = 0.
- result_valid  out  1  one-cycle pulse at job end.
- result_index  out  $clog2(MAX_LEN)  global index of the max.
- result_max  out  16  max magnitude; bit15 always 0.

Behaviour:
- Reset: state=IDLE. busy, s_ready, eng_in_valid, result_valid = 0. result_index and result_max = 0. All counters 0.
- States:
  - IDLE: start=1 latches len and computes nchunks = ceil(len/LANES). Next state is RUN, or DONE if len==0. Running max and index clear to 0.
  - RUN: s_ready = (issued < nchunks). On s_valid&s_ready: eng_in_valid=1 combinationally, eng_vector = s_data, issued++. Moves to DRAIN the cycle after the last chunk is accepted.
  - DRAIN: s_ready=0. Stays until received == nchunks, then goes to DONE.
  - DONE: result_valid=1 for exactly one cycle, then IDLE.
- eng_out_valid is accepted in RUN and DRAIN; received++ on each strobe. Strobes in IDLE/DONE are ignored; these are stale results after reset.
- Tail masking: on the last chunk, if len%LANES != 0, lanes >= len%LANES are forced to 16'h0000 on eng_vector.
- Update on each accepted result:
  - cand_idx = received*LANES + eng_index.
  - If eng_c[14:0] > run_max[14:0] (strict, unsigned raw compare), set run_max=eng_c and run_idx=cand_idx.
  - Strict compare means ties keep the lower index, and padded lanes never win.
- Raw compare places NaN above +inf; no special casing.
- len==0: result_valid 1 cycle after start, with max=0 and index=0. No chunk is issued.
- result_index and result_max load in DONE and hold until the next start.
- start while busy is ignored. len > MAX_LEN is clamped to MAX_LEN.
- rst mid-job: next cycle state is IDLE, with no result_valid and counters cleared.
- Latency = nchunks issue beats + engine latency + 2 cycles (result register, DONE).
- Assertion: received <= issued, and no strobe arrives more than LAT_MAX cycles after an outstanding issue.

Decomposition:
- Package half_max_pkg:
  - typedef half_t = logic[15:0];
  - constant HALF_MAG_MASK = 15'h7FFF;
  - function half_mag(half_t) returning [14:0].
- Sub-module half_max_abs_acc: running max/index register with clear, update-enable, cand_mag and cand_idx inputs, and a strict-greater compare.
- The FSM, counters and tail masking stay in the top.

Test Plan:
- Single chunk, length 8, fixed engine model with latency 3, LANES=8. Element 5=16'hBC00, all others 16'h3800. Expect result_max=16'h3C00, result_index=5. result_valid 5 cycles after the single accept.
- Three chunks with tail masking, length 20. Element 17=16'h4000, element 22=16'h5000 (outside len), others 16'h3C00. Expect eng_vector lanes 4..7 = 0 on chunk 2, result_index=17, result_max=16'h4000.
- Tie handling. Elements 3 and 11 = 16'h4200, others 0, length 16. Expect result_index=3.
- Zero length, len=0. Expect s_ready never high, eng_in_valid never high. result_valid in the cycle after start, with max=0 and index=0.
- Throttled input plus ignored start. s_valid toggles every other cycle, and start with len=8 is pulsed during RUN. Expect the result identical to the unthrottled run, and exactly one result_valid.
- Reset mid-job. rst asserted after 2 of 4 chunks are accepted, and the engine model still returns 2 strobes. Expect no result_valid and busy=0. A following start with len=8 gives the correct result.
